// File: rtl/rs_alu.sv
// rs_alu: reservation station in front of the integer ALU.
//
// Holds up to RS_SIZE issued ALU operations. Each entry waits until both of
// its operands are available, taking them from the ALU and load/store common
// data buses. One ready entry is sent to the ALU per cycle.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   rdy                        global ready; low stalls everything
//   flush                      misprediction clear (drops every entry)
//   inst_*                     issue request from the decoder
//   full                       every entry busy (no same-cycle dispatch credit)
//   cdb_alu_*, cdb_lsb_*       result broadcasts snooped for pending operands
//   alu_valid, alu_*           registered dispatch to the ALU
module rs_alu #(
    parameter int RS_SIZE = 4,
    parameter int ROB_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             inst_valid,
    input  logic [4:0]       inst_work_type,
    input  logic [ROB_W-1:0] inst_rob_id,
    input  logic [31:0]      inst_v1,
    input  logic [31:0]      inst_v2,
    input  logic             inst_q1_pending,
    input  logic             inst_q2_pending,
    input  logic [ROB_W-1:0] inst_q1,
    input  logic [ROB_W-1:0] inst_q2,
    output logic             full,
    input  logic             cdb_alu_ready,
    input  logic [ROB_W-1:0] cdb_alu_rob_id,
    input  logic [31:0]      cdb_alu_value,
    input  logic             cdb_lsb_ready,
    input  logic [ROB_W-1:0] cdb_lsb_rob_id,
    input  logic [31:0]      cdb_lsb_value,
    output logic             alu_valid,
    output logic [4:0]       alu_work_type,
    output logic [31:0]      alu_r1,
    output logic [31:0]      alu_r2,
    output logic [ROB_W-1:0] alu_rob_id
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] q1p_q, q1p_d;
    logic [RS_SIZE-1:0] q2p_q, q2p_d;
    logic [4:0]         wt_q  [RS_SIZE];
    logic [4:0]         wt_d  [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE];
    logic [ROB_W-1:0]   rob_d [RS_SIZE];
    logic [ROB_W-1:0]   q1_q  [RS_SIZE];
    logic [ROB_W-1:0]   q1_d  [RS_SIZE];
    logic [ROB_W-1:0]   q2_q  [RS_SIZE];
    logic [ROB_W-1:0]   q2_d  [RS_SIZE];
    logic [31:0]        v1_q  [RS_SIZE];
    logic [31:0]        v1_d  [RS_SIZE];
    logic [31:0]        v2_q  [RS_SIZE];
    logic [31:0]        v2_d  [RS_SIZE];

    logic             alu_valid_d;
    logic [4:0]       alu_work_type_d;
    logic [31:0]      alu_r1_d, alu_r2_d;
    logic [ROB_W-1:0] alu_rob_id_d;

    logic [IDX_W-1:0] free_idx, disp_idx;
    logic             disp_found;

    assign full = &busy_q;

    // Resolve an operand against both buses: returns {still_pending, value}.
    // The ALU bus is checked last so it wins when both carry the same tag.
    function automatic logic [32:0] resolve(input logic pend, input logic [ROB_W-1:0] tag,
                                            input logic [31:0] val);
        logic [32:0] r;
        r = {pend, val};
        if (pend && cdb_lsb_ready && cdb_lsb_rob_id == tag) r = {1'b0, cdb_lsb_value};
        if (pend && cdb_alu_ready && cdb_alu_rob_id == tag) r = {1'b0, cdb_alu_value};
        return r;
    endfunction

    // Lowest-index free entry and lowest-index ready entry, from registered state only.
    always_comb begin
        free_idx   = '0;
        disp_idx   = '0;
        disp_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IDX_W'(i);
            if (busy_q[i] && !q1p_q[i] && !q2p_q[i]) begin
                disp_idx   = IDX_W'(i);
                disp_found = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        q1p_d  = q1p_q;
        q2p_d  = q2p_q;
        wt_d   = wt_q;
        rob_d  = rob_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        alu_valid_d     = alu_valid;
        alu_work_type_d = alu_work_type;
        alu_r1_d        = alu_r1;
        alu_r2_d        = alu_r2;
        alu_rob_id_d    = alu_rob_id;

        if (flush) begin
            busy_d      = '0;
            alu_valid_d = 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    {q1p_d[i], v1_d[i]} = resolve(q1p_q[i], q1_q[i], v1_q[i]);
                    {q2p_d[i], v2_d[i]} = resolve(q2p_q[i], q2_q[i], v2_q[i]);
                end
            end

            alu_valid_d = disp_found;
            if (disp_found) begin
                alu_work_type_d  = wt_q[disp_idx];
                alu_r1_d         = v1_q[disp_idx];
                alu_r2_d         = v2_q[disp_idx];
                alu_rob_id_d     = rob_q[disp_idx];
                busy_d[disp_idx] = 1'b0;
            end

            // free_idx is never the dispatched entry: one is idle, the other busy.
            if (inst_valid && !full) begin
                busy_d[free_idx] = 1'b1;
                wt_d[free_idx]   = inst_work_type;
                rob_d[free_idx]  = inst_rob_id;
                q1_d[free_idx]   = inst_q1;
                q2_d[free_idx]   = inst_q2;
                {q1p_d[free_idx], v1_d[free_idx]} = resolve(inst_q1_pending, inst_q1, inst_v1);
                {q2p_d[free_idx], v2_d[free_idx]} = resolve(inst_q2_pending, inst_q2, inst_v2);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            q1p_q         <= '0;
            q2p_q         <= '0;
            alu_valid     <= 1'b0;
            alu_work_type <= '0;
            alu_r1        <= '0;
            alu_r2        <= '0;
            alu_rob_id    <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                wt_q[i]  <= '0;
                rob_q[i] <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
            end
        end else begin
            busy_q        <= busy_d;
            q1p_q         <= q1p_d;
            q2p_q         <= q2p_d;
            wt_q          <= wt_d;
            rob_q         <= rob_d;
            q1_q          <= q1_d;
            q2_q          <= q2_d;
            v1_q          <= v1_d;
            v2_q          <= v2_d;
            alu_valid     <= alu_valid_d;
            alu_work_type <= alu_work_type_d;
            alu_r1        <= alu_r1_d;
            alu_r2        <= alu_r2_d;
            alu_rob_id    <= alu_rob_id_d;
        end
    end

endmodule
